mem_lsu: RTL
============

# mem_lsu

Parametrised load/store unit replacing the combinational MEM stage of the five-stage MIPS pipeline. Sits between EX/MEM and MEM/WB. Drives a request/acknowledge data-memory port with variable latency, generates byte strobes for 32- or 64-bit buses in either endianness, and adds unsigned loads, address-error detection, flush and a registered writeback stage.

## Interface
- DATA_W, 32: memory and register data width; 32 or 64 only.
- ADDR_W, 32: address width.
- BIG_ENDIAN, 1: 1 means byte offset 0 is lane MSB; 0 means byte offset 0 is lane LSB.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- op_valid  in  1  EX/MEM holds a valid instruction.
- op  in  4  lsu_op_t: NOP, LB, LBU, LH, LHU, LW, LWU, LD, SB, SH, SW, SD.
- addr  in  ADDR_W  effective address.
- st_data  in  DATA_W  store source register.
- rd_i / wreg_i / alu_i  in  5 / 1 / DATA_W  destination, write enable, ALU result.
- flush  in  1  kill current/in-flight instruction's writeback.
- mem_req  out  1  request, held until mem_ack.
- mem_we  out  1  1 means store.
- mem_be  out  DATA_W/8  byte strobes.
- mem_addr  out  ADDR_W  addr aligned down to DATA_W/8.
- mem_wdata  out  DATA_W  lane-replicated store data.
- mem_ack  in  1  request complete; mem_rdata valid same cycle.
- mem_rdata  in  DATA_W  read data.
- stallreq  out  1  freeze stages upstream.
- wb_valid / wb_rd / wb_we / wb_data  out  1 / 5 / 1 / DATA_W  registered writeback.
- exc_adel / exc_ades  out  1  load / store address error, one-cycle pulse.
- badvaddr  out  ADDR_W  faulting address, valid with exc pulse.

## Operation
- States: IDLE, BUSY.
- Sizes: B=1, H=2, W=4, D=8 bytes. LWU, LD and SD are legal only when DATA_W=64; otherwise they are treated as NOP.
- Misaligned: H with addr[0]≠0; W with addr[1:0]≠0; D with addr[2:0]≠0.
- Lane offset k is addr[log2(DATA_W/8)-1:0].
  - mem_be has SIZE consecutive bits set, starting at lane k.
  - Lane k maps to bits [DATA_W-1-8k -: 8] when BIG_ENDIAN=1, and to [8k +: 8] when BIG_ENDIAN=0.
- Store data is replicated DATA_W/(8·SIZE) times.
- Load data is the addressed SIZE bytes:
  - LB, LH, LW, LD are sign-extended to DATA_W.
  - LBU, LHU, LWU are zero-extended to DATA_W.
- IDLE, op_valid and not flush:
  - Non-memory op or NOP: register alu_i, rd_i, wreg_i to wb_* next cycle; wb_valid=1.
  - Misaligned memory op: no request. Next cycle: wb_valid=1, wb_we=0, exc_adel (loads) or exc_ades (stores)=1, badvaddr=addr.
  - Aligned memory op: capture op, addr, st_data, rd_i. Next cycle → BUSY with mem_req=1 and mem_be/mem_addr/mem_wdata/mem_we driven from the captured values.
- BUSY:
  - mem_req and all mem_* outputs are held stable until mem_ack.
  - On mem_ack: → IDLE and mem_req drops next cycle.
  - Next cycle after mem_ack: wb_valid=1. Loads give wb_we=1 and wb_data=extracted value. Stores give wb_we=0.
  - Inputs are ignored in BUSY.
- stallreq = (IDLE ∧ op_valid ∧ aligned memory op ∧ ¬flush) ∨ (BUSY ∧ ¬mem_ack). It is combinational.
- flush:
  - In IDLE: the op is not accepted and wb_valid=0 next cycle.
  - In BUSY: the request still completes (memory is never abandoned), but a sticky kill flag forces wb_valid=0 on completion.
  - A store already in BUSY is still written.
- Reset: state=IDLE, kill=0, and every output is 0: mem_req, mem_we, mem_be, mem_addr, mem_wdata, stallreq, wb_*, exc_*, badvaddr. rst overrides mem_ack in the same cycle.

## Timing
- Non-memory op: writeback 1 cycle after presentation.
- Memory op with ack after N≥1 BUSY cycles: mem_req from cycle 1 to cycle N; wb_valid at cycle N+1. Throughput is one memory op per N+1 cycles.
- stallreq falls in the ack cycle. Upstream advances at that edge, and the next op is seen in IDLE in cycle N+1.
- wb_valid, exc_* and badvaddr are single-cycle pulses.
- rst mid-BUSY drops mem_req next cycle. The memory model must tolerate an abandoned request.

## Structure
- Package lsu_pkg holds:
  - lsu_op_t encoding: NOP=0, LB=1, LBU=2, LH=3, LHU=4, LW=5, LWU=6, LD=7, SB=8, SH=9, SW=10, SD=11.
  - lsu_state_t.
  - Functions is_load, is_store, op_size.
- One combinational sub-module, lsu_lane_align: computes byte enables, store replication and load extraction/extension from op, offset, DATA_W and BIG_ENDIAN. The FSM and registers live in mem_lsu.

## Test plan
- DATA_W=32, BIG_ENDIAN=1: SB addr=0x1001, st_data=0xAB → mem_be=0100, mem_wdata=0xABABABAB, mem_addr=0x1000, wb_we=0.
- LB addr=0x1002, rdata=0x1234F600, 3-cycle ack → mem_req held 3 cycles, stallreq high until the ack cycle, wb_data=0xFFFFFFF6. The same case as LBU gives 0x000000F6.
- DATA_W=64, BIG_ENDIAN=0: LWU addr=0x24, rdata=0x89ABCDEF_01234567 → mem_be=0xF0, wb_data=0x00000000_89ABCDEF.
- LW addr=0x2002 → no mem_req, exc_adel pulse, badvaddr=0x2002, wb_we=0. SH addr=0x3 → exc_ades pulse.
- SW in BUSY with flush pulsed in the first BUSY cycle → write still issued; no wb_valid on completion. The next ADD gets wb_valid 1 cycle later.
- rst asserted mid-BUSY → all outputs 0 next cycle; a subsequent LW completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and helpers for the load/store unit.
//   lsu_op_t    - 4-bit memory operation encoding presented by EX/MEM
//   lsu_state_t - request FSM states
//   is_load / is_store / op_size - operation classification helpers
package lsu_pkg;

  typedef enum logic [3:0] {
    NOP = 4'd0,
    LB  = 4'd1,
    LBU = 4'd2,
    LH  = 4'd3,
    LHU = 4'd4,
    LW  = 4'd5,
    LWU = 4'd6,
    LD  = 4'd7,
    SB  = 4'd8,
    SH  = 4'd9,
    SW  = 4'd10,
    SD  = 4'd11
  } lsu_op_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } lsu_state_t;

  function automatic logic is_load(lsu_op_t op);
    return (op == LB) || (op == LBU) || (op == LH) || (op == LHU) ||
           (op == LW) || (op == LWU) || (op == LD);
  endfunction

  function automatic logic is_store(lsu_op_t op);
    return (op == SB) || (op == SH) || (op == SW) || (op == SD);
  endfunction

  // Access size in bytes; 0 for anything that does not touch memory.
  function automatic logic [3:0] op_size(lsu_op_t op);
    case (op)
      LB, LBU, SB: return 4'd1;
      LH, LHU, SH: return 4'd2;
      LW, LWU, SW: return 4'd4;
      LD, SD:      return 4'd8;
      default:     return 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: combinational byte-lane steering for the load/store unit.
//   op       - lsu_op_t encoding of the access
//   offset   - byte offset of the access within the data bus word
//   st_data  - store source register, replicated onto every lane group
//   rdata    - raw memory read data
//   be       - byte strobes, bit i covers data bits [8i +: 8]
//   wdata    - replicated store data
//   ld_data  - addressed bytes, sign- or zero-extended to DATA_W
module lsu_lane_align
  import lsu_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter bit BIG_ENDIAN = 1'b1,
  localparam int NB        = DATA_W / 8,
  localparam int OFF_W     = $clog2(NB)
) (
  input  logic [3:0]        op,
  input  logic [OFF_W-1:0]  offset,
  input  logic [DATA_W-1:0] st_data,
  input  logic [DATA_W-1:0] rdata,
  output logic [NB-1:0]     be,
  output logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] ld_data
);

  lsu_op_t           op_t;
  logic [3:0]        size;
  logic              signed_ld;
  int                sh_bytes;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] mask;
  logic [DATA_W-1:0] sign_mask;
  logic              sign_bit;

  assign op_t      = lsu_op_t'(op);
  assign size      = op_size(op_t);
  assign signed_ld = (op_t == LB) || (op_t == LH) || (op_t == LW) || (op_t == LD);

  // Physical byte gi holds lane gi (little endian) or lane NB-1-gi (big endian).
  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_be
      localparam int LANE = BIG_ENDIAN ? (NB - 1 - gi) : gi;
      assign be[gi] = (LANE >= int'(offset)) && (LANE < int'(offset) + int'(size));
    end
  endgenerate

  // Plain replication lands the operand correctly in either endianness:
  // its most significant byte sits in the highest physical byte of each group.
  always_comb begin
    wdata = st_data;
    case (size)
      4'd1:    wdata = {NB{st_data[7:0]}};
      4'd2:    wdata = {(NB / 2){st_data[15:0]}};
      4'd4:    wdata = {(NB / 4){st_data[31:0]}};
      default: wdata = st_data;
    endcase
  end

  // Move the addressed bytes down to bit 0, then mask and extend.
  always_comb begin
    if (BIG_ENDIAN) sh_bytes = NB - int'(offset) - int'(size);
    else            sh_bytes = int'(offset);
    if (sh_bytes < 0) sh_bytes = 0;
    shifted   = rdata >> (8 * sh_bytes);
    mask      = ~({DATA_W{1'b1}} << (8 * size));
    sign_mask = mask & ~(mask >> 1);
    sign_bit  = signed_ld && (|(shifted & sign_mask));
    ld_data   = (shifted & mask) | ({DATA_W{sign_bit}} & ~mask);
  end

endmodule

// File: rtl/mem_lsu.sv
// mem_lsu: MEM-stage load/store unit with a request/acknowledge memory port.
//   clk, rst              - clock, synchronous active-high reset
//   op_valid/op/addr      - instruction from EX/MEM
//   st_data, rd_i, wreg_i, alu_i - store data and writeback fields
//   flush                 - kill the current or in-flight writeback
//   mem_*                 - data memory port, held stable while mem_req=1
//   stallreq              - freeze upstream stages
//   wb_*                  - registered writeback to MEM/WB (single-cycle pulse)
//   exc_adel/exc_ades, badvaddr - address-error pulse and faulting address
module mem_lsu
  import lsu_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                op_valid,
  input  logic [3:0]          op,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   st_data,
  input  logic [4:0]          rd_i,
  input  logic                wreg_i,
  input  logic [DATA_W-1:0]   alu_i,
  input  logic                flush,
  output logic                mem_req,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_ack,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                stallreq,
  output logic                wb_valid,
  output logic [4:0]          wb_rd,
  output logic                wb_we,
  output logic [DATA_W-1:0]   wb_data,
  output logic                exc_adel,
  output logic                exc_ades,
  output logic [ADDR_W-1:0]   badvaddr
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);

  lsu_state_t        state_reg, state_next;
  logic              kill_reg;
  lsu_op_t           op_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] st_data_reg;
  logic [4:0]        rd_reg;

  logic              wb_valid_reg, wb_we_reg, exc_adel_reg, exc_ades_reg;
  logic [4:0]        wb_rd_reg;
  logic [DATA_W-1:0] wb_data_reg;
  logic [ADDR_W-1:0] badvaddr_reg;

  lsu_op_t           op_in;
  logic [3:0]        in_size;
  logic              in_load, in_store, in_mem, in_misaligned;
  logic              accept, start_mem, mem_done;

  logic [NB-1:0]     al_be;
  logic [DATA_W-1:0] al_wdata, al_ld_data;

  // 64-bit-only operations degrade to NOP on a 32-bit bus.
  always_comb begin
    op_in = lsu_op_t'(op);
    if (DATA_W != 64 && (op_in == LWU || op_in == LD || op_in == SD)) op_in = NOP;
  end

  assign in_size  = op_size(op_in);
  assign in_load  = is_load(op_in);
  assign in_store = is_store(op_in);
  assign in_mem   = in_load || in_store;
  // size-1 is the mask of address bits that must be zero (sizes are powers of two).
  assign in_misaligned = in_mem && (((in_size - 4'd1) & {1'b0, addr[2:0]}) != 4'd0);

  assign accept    = (state_reg == IDLE) && op_valid && !flush;
  assign start_mem = accept && in_mem && !in_misaligned;
  assign mem_done  = (state_reg == BUSY) && mem_ack;

  lsu_lane_align #(
    .DATA_W     (DATA_W),
    .BIG_ENDIAN (BIG_ENDIAN)
  ) u_align (
    .op      (op_reg),
    .offset  (addr_reg[OFF_W-1:0]),
    .st_data (st_data_reg),
    .rdata   (mem_rdata),
    .be      (al_be),
    .wdata   (al_wdata),
    .ld_data (al_ld_data)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start_mem) state_next = BUSY;
      BUSY:    if (mem_ack) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Memory port and stall outputs; the port is quiet outside BUSY.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    stallreq  = 1'b0;
    if (state_reg == BUSY) begin
      mem_req   = 1'b1;
      mem_we    = is_store(op_reg);
      mem_be    = al_be;
      mem_addr  = addr_reg & ~ADDR_W'(NB - 1);
      mem_wdata = al_wdata;
      stallreq  = !mem_ack;
    end else begin
      stallreq  = op_valid && !flush && in_mem && !in_misaligned;
    end
    if (rst) stallreq = 1'b0;
  end

  // Captured request, sticky kill and the writeback/exception pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      kill_reg     <= 1'b0;
      op_reg       <= NOP;
      addr_reg     <= '0;
      st_data_reg  <= '0;
      rd_reg       <= '0;
      wb_valid_reg <= 1'b0;
      wb_we_reg    <= 1'b0;
      wb_rd_reg    <= '0;
      wb_data_reg  <= '0;
      exc_adel_reg <= 1'b0;
      exc_ades_reg <= 1'b0;
      badvaddr_reg <= '0;
    end else begin
      wb_valid_reg <= 1'b0;
      wb_we_reg    <= 1'b0;
      wb_rd_reg    <= '0;
      wb_data_reg  <= '0;
      exc_adel_reg <= 1'b0;
      exc_ades_reg <= 1'b0;
      badvaddr_reg <= '0;

      if (start_mem) begin
        op_reg      <= op_in;
        addr_reg    <= addr;
        st_data_reg <= st_data;
        rd_reg      <= rd_i;
        kill_reg    <= 1'b0;
      end

      // The memory access is never abandoned; only its writeback is dropped.
      if (state_reg == BUSY && flush) kill_reg <= 1'b1;

      if (accept && !in_mem) begin
        wb_valid_reg <= 1'b1;
        wb_we_reg    <= wreg_i;
        wb_rd_reg    <= rd_i;
        wb_data_reg  <= alu_i;
      end

      if (accept && in_misaligned) begin
        wb_valid_reg <= 1'b1;
        wb_rd_reg    <= rd_i;
        exc_adel_reg <= in_load;
        exc_ades_reg <= in_store;
        badvaddr_reg <= addr;
      end

      if (mem_done && !(kill_reg || flush)) begin
        wb_valid_reg <= 1'b1;
        wb_rd_reg    <= rd_reg;
        if (is_load(op_reg)) begin
          wb_we_reg   <= 1'b1;
          wb_data_reg <= al_ld_data;
        end
      end
    end
  end

  assign wb_valid = wb_valid_reg;
  assign wb_we    = wb_we_reg;
  assign wb_rd    = wb_rd_reg;
  assign wb_data  = wb_data_reg;
  assign exc_adel = exc_adel_reg;
  assign exc_ades = exc_ades_reg;
  assign badvaddr = badvaddr_reg;

endmodule
